// File: rtl/traffic_phase_controller.sv
// Two-approach traffic phase controller: NS/EW greens with yellow and
// all-red clearance, demand latches per direction and min/max green timing.
module traffic_phase_controller #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 12,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       EWCar,
  input  logic       NSCar,
  output logic [2:0] EWLite,
  output logic [2:0] NSLite,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NsGreen  = 3'd0,
    NsYellow = 3'd1,
    RedToEw  = 3'd2,
    EwGreen  = 3'd3,
    EwYellow = 3'd4,
    RedToNs  = 3'd5
  } state_e;

  // Terminal counts expressed as the cnt value seen on the exit edge.
  localparam logic [7:0] MinLast    = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MaxLast    = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YellowLast = 8'(YELLOW - 1);
  localparam logic [7:0] RedLast    = 8'(ALL_RED - 1);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  state_e     state_q, state_d;
  logic [7:0] cnt;
  logic       ew_pend, ns_pend;
  logic       xreq;

  // Lamp pattern {EWLite, NSLite} for a state; unreachable codes show all red.
  function automatic logic [5:0] lamps(input state_e s);
    logic [5:0] l;
    l = {LampRed, LampRed};
    case (s)
      NsGreen:  l = {LampRed, LampGreen};
      NsYellow: l = {LampRed, LampYellow};
      EwGreen:  l = {LampGreen, LampRed};
      EwYellow: l = {LampYellow, LampRed};
      default:  l = {LampRed, LampRed};
    endcase
    return l;
  endfunction

  // Next-state: greens exit on cross demand, yellow/all-red run fixed durations.
  always_comb begin
    state_d = state_q;
    xreq    = 1'b0;
    case (state_q)
      NsGreen: begin
        xreq = EWCar | ew_pend;
        if (xreq && ((cnt >= MinLast && !NSCar) || cnt >= MaxLast)) state_d = NsYellow;
      end
      NsYellow: if (cnt == YellowLast) state_d = RedToEw;
      RedToEw:  if (cnt == RedLast)    state_d = EwGreen;
      EwGreen: begin
        xreq = NSCar | ns_pend;
        if (xreq && ((cnt >= MinLast && !EWCar) || cnt >= MaxLast)) state_d = EwYellow;
      end
      EwYellow: if (cnt == YellowLast) state_d = RedToNs;
      RedToNs:  if (cnt == RedLast)    state_d = NsGreen;
      default:  state_d = NsGreen;
    endcase
  end

  // State, dwell counter, demand latches and registered Moore outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= NsGreen;
      cnt     <= 8'd0;
      ew_pend <= 1'b0;
      ns_pend <= 1'b0;
      EWLite  <= LampRed;
      NSLite  <= LampGreen;
      phase   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  cnt <= 8'd0;
      else if (cnt != 8'hff)   cnt <= cnt + 8'd1;
      // Clearing on green entry takes precedence over a same-edge set.
      if (state_d == EwGreen && state_q != EwGreen) ew_pend <= 1'b0;
      else if (EWCar && state_q != EwGreen)         ew_pend <= 1'b1;
      if (state_d == NsGreen && state_q != NsGreen) ns_pend <= 1'b0;
      else if (NSCar && state_q != NsGreen)         ns_pend <= 1'b1;
      {EWLite, NSLite} <= lamps(state_d);
      phase            <= state_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: stimulus pushes the expected
// phase after each edge; a negedge monitor pops and compares lamps/phase/latches.
module tb_traffic_phase_controller;

  logic       clock = 1'b0;
  logic       reset0, reset1, ew, ns;
  logic [2:0] ew_lite0, ns_lite0, phase0;
  logic [2:0] ew_lite1, ns_lite1, phase1;

  always #5 clock = ~clock;

  traffic_phase_controller dut0 (
    .clock (clock),
    .reset (reset0),
    .EWCar (ew),
    .NSCar (ns),
    .EWLite(ew_lite0),
    .NSLite(ns_lite0),
    .phase (phase0)
  );

  traffic_phase_controller #(
    .MIN_GREEN(1),
    .MAX_GREEN(1),
    .YELLOW   (1),
    .ALL_RED  (1)
  ) dut1 (
    .clock (clock),
    .reset (reset1),
    .EWCar (ew),
    .NSCar (ns),
    .EWLite(ew_lite1),
    .NSLite(ns_lite1),
    .phase (phase1)
  );

  typedef struct {
    bit         dut;
    logic [2:0] ph;
    bit         chk_pend;
    bit         ep;
    bit         np;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return {3'b100, 3'b001};
      3'd1:    return {3'b100, 3'b010};
      3'd3:    return {3'b001, 3'b100};
      3'd4:    return {3'b010, 3'b100};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Phase after the edge numbered m (reset edge = 0) with both sensors held.
  function automatic logic [2:0] both_held(input int m);
    if (m < 12) return 3'd0;
    if (m < 15) return 3'd1;
    if (m < 16) return 3'd2;
    if (m < 28) return 3'd3;
    if (m < 31) return 3'd4;
    return 3'd5;
  endfunction

  function automatic void check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endfunction

  // Monitor: one expected entry per cycle, compared away from the active edge.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [5:0] l;
      e = q.pop_front();
      l = exp_lamps(e.ph);
      if (e.dut) begin
        check("phase1", phase1, e.ph);
        check("ewlite1", ew_lite1, l[5:3]);
        check("nslite1", ns_lite1, l[2:0]);
      end else begin
        check("phase0", phase0, e.ph);
        check("ewlite0", ew_lite0, l[5:3]);
        check("nslite0", ns_lite0, l[2:0]);
        if (e.chk_pend) begin
          check("ew_pend", {2'b00, dut0.ew_pend}, {2'b00, e.ep});
          check("ns_pend", {2'b00, dut0.ns_pend}, {2'b00, e.np});
        end
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit n, input logic [2:0] ph,
                      input bit cp = 1'b0, input bit ep = 1'b0, input bit np = 1'b0);
    exp_t x;
    reset0 = r;
    ew     = e;
    ns     = n;
    @(posedge clock);
    #1;
    x.dut = 1'b0; x.ph = ph; x.chk_pend = cp; x.ep = ep; x.np = np;
    q.push_back(x);
  endtask

  task automatic step1(input bit r, input logic [2:0] ph);
    exp_t x;
    reset0 = 1'b1;
    reset1 = r;
    ew     = 1'b1;
    ns     = 1'b1;
    @(posedge clock);
    #1;
    x.dut = 1'b1; x.ph = ph; x.chk_pend = 1'b0; x.ep = 1'b0; x.np = 1'b0;
    q.push_back(x);
  endtask

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    ew     = 1'b0;
    ns     = 1'b0;

    // Reset then idle: NS green forever.
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (50) step(0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Single EW pulse on the 10th edge after reset.
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (9) step(0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 2, 1, 1, 0);
    step(0, 0, 0, 3, 1, 0, 0);
    repeat (10) step(0, 0, 0, 3, 1, 0, 0);

    // Both sensors held: 12-cycle greens, 32-cycle period.
    step(1, 1, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 64; k++) step(0, 1, 1, both_held(k % 32));

    // EW green shortened to 4 cycles by NS pulse and EW drop.
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 1);
    step(0, 1, 0, 2);
    step(0, 1, 0, 3, 1, 0, 0);
    step(0, 1, 0, 3);
    step(0, 1, 1, 3, 1, 0, 1);
    step(0, 0, 0, 3);
    step(0, 0, 0, 4);
    step(0, 0, 0, 4);
    step(0, 0, 0, 4);
    step(0, 0, 0, 5);
    step(0, 0, 0, 0, 1, 0, 0);

    // Demand during yellow, then reset in mid EW yellow.
    step(1, 0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1, 1, 1, 0);
    step(0, 0, 0, 2, 1, 1, 0);
    step(0, 0, 0, 3, 1, 0, 0);
    repeat (3) step(0, 0, 1, 3);
    step(0, 0, 1, 4);
    step(0, 0, 1, 4, 1, 0, 1);
    step(1, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    // Minimal timing instance: 6-cycle rotation through every phase.
    step1(1, 0);
    for (int k = 1; k <= 18; k++) step1(0, 3'(k % 6));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

Interface
REQ-001 Parameter MIN_GREEN, default 4, minimum green cycles before a demand-driven switch; legal range 1..MAX_GREEN.
REQ-002 Parameter MAX_GREEN, default 12, green cycles after which a waiting demand forces a switch; legal range MIN_GREEN..255.
REQ-003 Parameter YELLOW, default 3, yellow cycles; legal range 1..255.
REQ-004 Parameter ALL_RED, default 1, all-red clearance cycles; legal range 1..255.
REQ-005 Port clock, input, 1, single clock; all state updates on posedge.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port EWCar, input, 1, level car sensor for the east-west approach.
REQ-008 Port NSCar, input, 1, level car sensor for the north-south approach.
REQ-009 Port EWLite, output, 3, east-west lamps, one-hot: bit2 red, bit1 yellow, bit0 green.
REQ-010 Port NSLite, output, 3, north-south lamps, same encoding.
REQ-011 Port phase, output, 3, current state code per REQ-013.

Function
REQ-012 Moore machine: EWLite, NSLite and phase decode from the state register only; no combinational input-to-output path.
REQ-013 States/codes: NS_GREEN=0, NS_YELLOW=1, RED_TO_EW=2, EW_GREEN=3, EW_YELLOW=4, RED_TO_NS=5; codes 6-7 unreachable and recover to NS_GREEN on the next edge.
REQ-014 Lamps: NS_GREEN NS=001/EW=100; NS_YELLOW 010/100; RED_TO_EW and RED_TO_NS 100/100; EW_GREEN 100/001; EW_YELLOW 100/010.
REQ-015 8-bit cnt clears to 0 on every state change, otherwise increments, saturating at 255.
REQ-016 Demand latches ew_pend/ns_pend: set on any edge where the sensor is 1 and that direction is not in its green state; cleared on the edge entering that direction's green; clear wins over a simultaneous set.
REQ-017 Cross demand: in NS_GREEN xreq = EWCar|ew_pend; in EW_GREEN xreq = NSCar|ns_pend.
REQ-018 Green exit (own sensor = NSCar in NS_GREEN, EWCar in EW_GREEN), evaluated each edge: xreq && ((cnt >= MIN_GREEN-1 && own sensor==0) || cnt >= MAX_GREEN-1).
REQ-019 Without xreq, green holds indefinitely; the cnt saturation does not trigger a change.
REQ-020 Yellow lasts exactly YELLOW cycles: exit on the edge with cnt==YELLOW-1; NS_YELLOW->RED_TO_EW, EW_YELLOW->RED_TO_NS.
REQ-021 All-red lasts exactly ALL_RED cycles: exit on the edge with cnt==ALL_RED-1; RED_TO_EW->EW_GREEN, RED_TO_NS->NS_GREEN.
REQ-022 Yellow and all-red states are never aborted or extended by sensor inputs; demand latching per REQ-016 still operates during them.
REQ-023 Neither direction is ever green or yellow while the other is green or yellow.

Reset
REQ-024 While reset=1 at an edge: state NS_GREEN, cnt=0, ew_pend=ns_pend=0; outputs NSLite=001, EWLite=100, phase=0 from the next cycle.
REQ-025 Reset has priority over all transitions and latch updates, in any state including mid-yellow and mid-all-red.

Verification
REQ-026 Reset, then 50 cycles with both sensors 0 -> NSLite=001, EWLite=100, phase=0 throughout.
REQ-027 Reset, then EWCar=1 for one cycle at edge 10 with NSCar=0 -> NS_YELLOW for 3 cycles, RED_TO_EW for 1 cycle, then EW_GREEN held with ew_pend=0.
REQ-028 Both sensors held at 1 -> each green lasts exactly 12 cycles; period 32 cycles (12+3+1 per direction); no overlap per REQ-023.
REQ-029 In EW_GREEN with EWCar=1: NSCar pulsed at cnt=1, EWCar dropped at cnt=2 -> exit to EW_YELLOW on the edge with cnt=3, i.e. a 4-cycle green.
REQ-030 EWCar asserted during NS_YELLOW -> yellow still exactly 3 cycles and ew_pend=1; reset asserted at EW_YELLOW cnt=1 -> NS_GREEN with both latches 0 on the next cycle.
REQ-031 Parameters MIN_GREEN=1, MAX_GREEN=1, YELLOW=1, ALL_RED=1 with both sensors held at 1 -> 6-cycle period alternating phases 0,1,2,3,4,5.
